// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (MIN_VAL..MAX_VAL) with up/down stepping,
// validated parallel load and registered carry/borrow/load-error pulses.
module bcd_mod_counter #(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 23,
  parameter int RST_VAL = MIN_VAL
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_low,
  input  logic [3:0] load_high,
  output logic [3:0] low,
  output logic [3:0] high,
  output logic       co,
  output logic       bo,
  output logic       load_err
);

  // Limits packed as {tens, units}; packed BCD compares in numeric order.
  localparam logic [7:0] MIN_BCD = 8'(((MIN_VAL / 10) * 16) + (MIN_VAL % 10));
  localparam logic [7:0] MAX_BCD = 8'(((MAX_VAL / 10) * 16) + (MAX_VAL % 10));
  localparam logic [7:0] RST_BCD = 8'(((RST_VAL / 10) * 16) + (RST_VAL % 10));

  logic [7:0] count;
  logic [7:0] load_bcd;
  logic       load_ok;
  logic [3:0] next_low;
  logic [3:0] next_high;
  logic       next_co;
  logic       next_bo;
  logic       next_err;

  assign count    = {high, low};
  assign load_bcd = {load_high, load_low};
  assign load_ok  = (load_high <= 4'd9) && (load_low <= 4'd9) &&
                    (load_bcd >= MIN_BCD) && (load_bcd <= MAX_BCD);

  always_comb begin
    next_low  = low;
    next_high = high;
    next_co   = 1'b0;
    next_bo   = 1'b0;
    next_err  = 1'b0;
    if (load) begin
      // A load owns the edge even when rejected; en is ignored.
      if (load_ok) begin
        next_high = load_high;
        next_low  = load_low;
      end else begin
        next_err = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (count == MAX_BCD) begin
          {next_high, next_low} = MIN_BCD;
          next_co = 1'b1;
        end else if (low == 4'd9) begin
          next_low  = 4'd0;
          next_high = high + 4'd1;
        end else begin
          next_low = low + 4'd1;
        end
      end else begin
        if (count == MIN_BCD) begin
          {next_high, next_low} = MAX_BCD;
          next_bo = 1'b1;
        end else if (low == 4'd0) begin
          next_low  = 4'd9;
          next_high = high - 4'd1;
        end else begin
          next_low = low - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      {high, low} <= RST_BCD;
      co          <= 1'b0;
      bo          <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      high     <= next_high;
      low      <= next_low;
      co       <= next_co;
      bo       <= next_bo;
      load_err <= next_err;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: default 0..23 instance, a 1..12 instance and a
// 0..59 -> 0..23 cascade, driven from a vector table plus short sequences.
module tb_bcd_mod_counter;

  typedef struct {
    int         sel;
    logic       rst;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] lh;
    logic [3:0] ll;
    logic [3:0] eh;
    logic [3:0] el;
    logic       eco;
    logic       ebo;
    logic       eerr;
  } vec_t;

  logic clkin = 1'b0;
  always #5 clkin = ~clkin;

  int n_vec = 0;
  int n_bad = 0;

  // Instance A: defaults 0..23
  logic       a_rst = 0, a_en = 0, a_up = 0, a_load = 0;
  logic [3:0] a_lh = 0, a_ll = 0;
  logic [3:0] a_h, a_l;
  logic       a_co, a_bo, a_err;

  // Instance B: 1..12, reset to 12
  logic       b_rst = 0, b_en = 0, b_up = 0, b_load = 0;
  logic [3:0] b_lh = 0, b_ll = 0;
  logic [3:0] b_h, b_l;
  logic       b_co, b_bo, b_err;

  // Cascade: lower 0..59 stage feeds upper default stage
  logic       c_rst = 0, c_en = 0, c_load = 0, c_up = 1;
  logic [3:0] c_lh0 = 0, c_ll0 = 0, c_lh1 = 0, c_ll1 = 0;
  logic [3:0] lo_h, lo_l, hi_h, hi_l;
  logic       lo_co, lo_bo, lo_err, hi_co, hi_bo, hi_err;

  bcd_mod_counter dut_a (
    .clkin(clkin), .rst(a_rst), .en(a_en), .up(a_up), .load(a_load),
    .load_low(a_ll), .load_high(a_lh), .low(a_l), .high(a_h),
    .co(a_co), .bo(a_bo), .load_err(a_err)
  );

  bcd_mod_counter #(.MIN_VAL(1), .MAX_VAL(12), .RST_VAL(12)) dut_b (
    .clkin(clkin), .rst(b_rst), .en(b_en), .up(b_up), .load(b_load),
    .load_low(b_ll), .load_high(b_lh), .low(b_l), .high(b_h),
    .co(b_co), .bo(b_bo), .load_err(b_err)
  );

  bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(59)) dut_lo (
    .clkin(clkin), .rst(c_rst), .en(c_en), .up(c_up), .load(c_load),
    .load_low(c_ll0), .load_high(c_lh0), .low(lo_l), .high(lo_h),
    .co(lo_co), .bo(lo_bo), .load_err(lo_err)
  );

  bcd_mod_counter dut_hi (
    .clkin(clkin), .rst(c_rst), .en(lo_co), .up(c_up), .load(c_load),
    .load_low(c_ll1), .load_high(c_lh1), .low(hi_l), .high(hi_h),
    .co(hi_co), .bo(hi_bo), .load_err(hi_err)
  );

  function automatic vec_t mk(int sel, logic rst, logic load, logic en, logic up,
                              logic [3:0] lh, logic [3:0] ll, logic [3:0] eh,
                              logic [3:0] el, logic eco, logic ebo, logic eerr);
    vec_t v;
    v.sel = sel; v.rst = rst; v.load = load; v.en = en; v.up = up;
    v.lh = lh; v.ll = ll; v.eh = eh; v.el = el;
    v.eco = eco; v.ebo = ebo; v.eerr = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] h, input logic [3:0] l,
                       input logic c, input logic b, input logic e,
                       input logic [3:0] eh, input logic [3:0] el,
                       input logic ec, input logic eb, input logic ee);
    n_vec++;
    if ({h, l, c, b, e} !== {eh, el, ec, eb, ee}) begin
      n_bad++;
      $display("FAIL %s: got %h%h co=%b bo=%b err=%b, expected %h%h co=%b bo=%b err=%b",
               name, h, l, c, b, e, eh, el, ec, eb, ee);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    // ---- table: sel 0 = instance A, sel 1 = instance B ----
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // reset -> 00
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 9, 0, 9, 0, 0, 0)); // load 09
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0)); // 09 -> 10
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 9, 0, 0, 0)); // 10 -> 09
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 5, 1, 5, 0, 0, 0)); // load 15
    vecs.push_back(mk(0, 0, 1, 1, 1, 2, 0, 2, 0, 0, 0, 0)); // load beats en
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 7, 0, 0, 0, 0, 0)); // rst beats all
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0)); // first step from RST_VAL
    vecs.push_back(mk(0, 0, 1, 0, 0, 2, 3, 2, 3, 0, 0, 0)); // load 23
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0)); // 23 -> 00 co
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0)); // co drops
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // load 00
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2, 3, 0, 1, 0)); // 00 -> 23 bo
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2, 2, 0, 0, 0)); // 23 -> 22
    vecs.push_back(mk(0, 0, 1, 1, 1, 2, 4, 2, 2, 0, 0, 1)); // 24 rejected, no step
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 10, 2, 2, 0, 0, 1)); // units 10 rejected
    vecs.push_back(mk(0, 0, 1, 0, 0, 10, 0, 2, 2, 0, 0, 1)); // tens 10 rejected
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2, 2, 0, 0, 0)); // hold, err drops
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 9, 1, 9, 0, 0, 0)); // load 19 with en down
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 8, 0, 0, 0)); // 19 -> 18
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0)); // B reset -> 12
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0)); // 12 -> 01 co
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 3, 0, 1, 0, 0, 1)); // 13 rejected
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1)); // 00 rejected
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 10, 0, 1, 0, 0, 1)); // 0/10 rejected
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 2, 0, 1, 0)); // 01 -> 12 bo
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0)); // 12 -> 11
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0)); // load 10 accepted

    foreach (vecs[i]) begin
      if (vecs[i].sel == 0) begin
        {a_rst, a_load, a_en, a_up} = {vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up};
        {a_lh, a_ll} = {vecs[i].lh, vecs[i].ll};
        {b_rst, b_load, b_en} = 3'b000;
      end else begin
        {b_rst, b_load, b_en, b_up} = {vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up};
        {b_lh, b_ll} = {vecs[i].lh, vecs[i].ll};
        {a_rst, a_load, a_en} = 3'b000;
      end
      tick();
      if (vecs[i].sel == 0)
        check($sformatf("vec%0d_a", i), a_h, a_l, a_co, a_bo, a_err,
              vecs[i].eh, vecs[i].el, vecs[i].eco, vecs[i].ebo, vecs[i].eerr);
      else
        check($sformatf("vec%0d_b", i), b_h, b_l, b_co, b_bo, b_err,
              vecs[i].eh, vecs[i].el, vecs[i].eco, vecs[i].ebo, vecs[i].eerr);
    end
    {b_rst, b_load, b_en} = 3'b000;

    // ---- full up sweep on A: 00..23 then wrap with a single co ----
    {a_rst, a_load, a_en, a_up} = 4'b1000;
    tick();
    check("sweep_rst", a_h, a_l, a_co, a_bo, a_err, 4'd0, 4'd0, 0, 0, 0);
    a_rst = 0; a_en = 1; a_up = 1;
    for (int i = 1; i <= 24; i++) begin
      int v;
      v = i % 24;
      tick();
      check($sformatf("sweep%0d", i), a_h, a_l, a_co, a_bo, a_err,
            4'(v / 10), 4'(v % 10), (i == 24), 0, 0);
    end
    a_en = 0;
    tick();
    check("sweep_hold", a_h, a_l, a_co, a_bo, a_err, 4'd0, 4'd0, 0, 0, 0);

    // ---- cascade 23:59 -> 00:00 ----
    c_rst = 1;
    tick();
    check("casc_rst_hi", hi_h, hi_l, hi_co, hi_bo, hi_err, 4'd0, 4'd0, 0, 0, 0);
    c_rst = 0; c_load = 1; {c_lh0, c_ll0} = 8'h59; {c_lh1, c_ll1} = 8'h23;
    tick();
    check("casc_load_lo", lo_h, lo_l, lo_co, lo_bo, lo_err, 4'd5, 4'd9, 0, 0, 0);
    check("casc_load_hi", hi_h, hi_l, hi_co, hi_bo, hi_err, 4'd2, 4'd3, 0, 0, 0);
    c_load = 0; c_en = 1;
    tick();
    check("casc_wrap_lo", lo_h, lo_l, lo_co, lo_bo, lo_err, 4'd0, 4'd0, 1, 0, 0);
    check("casc_wait_hi", hi_h, hi_l, hi_co, hi_bo, hi_err, 4'd2, 4'd3, 0, 0, 0);
    c_en = 0;
    tick();
    check("casc_wrap_hi", hi_h, hi_l, hi_co, hi_bo, hi_err, 4'd0, 4'd0, 1, 0, 0);
    check("casc_hold_lo", lo_h, lo_l, lo_co, lo_bo, lo_err, 4'd0, 4'd0, 0, 0, 0);
    tick();
    check("casc_co_drop", hi_h, hi_l, hi_co, hi_bo, hi_err, 4'd0, 4'd0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
